pipe_ctrl: RTL and testbench

// Parametrised pipeline sequencer for the in-order MIPS core: owns the valid bits and payload registers of

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_stage_reg.sv | 39 +++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Package: pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer and its users.
//   STG_D..STG_W : stage indices of the 5-stage core (0 = youngest register).
//   CORE_NSTAGE  : number of inter-stage registers in the core.
//   pcnt_t       : performance counter type at the core's default width.
package pipe_ctrl_pkg;

   localparam int unsigned STG_D       = 0;
   localparam int unsigned STG_E       = 1;
   localparam int unsigned STG_M       = 2;
   localparam int unsigned STG_W       = 3;
   localparam int unsigned CORE_NSTAGE = 4;
   localparam int unsigned CORE_CNTW   = 32;

   typedef logic [CORE_CNTW-1:0] pcnt_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Module: pipe_stage_reg
// One inter-stage register: a valid bit plus W payload bits, updated with
// priority kill > hold > load. A slot that neither holds nor loads becomes a
// bubble with zeroed payload, so a bubble carries a no-side-effect control word.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   kill       : discard the slot this cycle
//   hold       : keep the slot contents this cycle
//   load       : accept load_data as a real instruction
//   load_data  : payload offered by the previous stage (or fetch)
//   valid      : slot holds a real instruction
//   data       : slot payload
module pipe_stage_reg #(
   parameter int unsigned W = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         kill,
   input  logic         hold,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (kill) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (!hold) begin
         valid <= load;
         data  <= load ? load_data : '0;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Module: pipe_ctrl
// Pipeline sequencer for the in-order core. Owns NSTAGE valid/payload
// registers (index 0 = youngest) and derives per-stage hold, youngest-range
// flush, bubble insertion and retire from per-stage stall/flush requests.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   in_valid/data   : fetch offers an instruction into stage 0
//   in_ready        : stage 0 accepts in_data this cycle
//   stall_req[i]    : stage i cannot advance this cycle
//   flush_req[i]    : kill stages 0..i (highest set index wins)
//   stage_valid/data/hold : per-stage state and freeze indication
//   retire_valid/data     : oldest stage leaves the pipeline this cycle
//   retire_cnt, stall_cnt, flush_cnt : wrapping performance counters
// COLLAPSE = 0: any hold freezes every younger stage (lockstep).
// COLLAPSE = 1: an empty stage never holds, so stalls are absorbed by bubbles.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NSTAGE   = 4,
   parameter int unsigned W        = 128,
   parameter int unsigned COLLAPSE = 0,
   parameter int unsigned CNTW     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [W-1:0]        in_data,
   output logic                in_ready,
   input  logic [NSTAGE-1:0]   stall_req,
   input  logic [NSTAGE-1:0]   flush_req,
   output logic [NSTAGE-1:0]   stage_valid,
   output logic [NSTAGE*W-1:0] stage_data,
   output logic [NSTAGE-1:0]   stage_hold,
   output logic                retire_valid,
   output logic [W-1:0]        retire_data,
   output logic [CNTW-1:0]     retire_cnt,
   output logic [CNTW-1:0]     stall_cnt,
   output logic [CNTW-1:0]     flush_cnt
);

   logic [NSTAGE-1:0]   valid;
   logic [NSTAGE*W-1:0] data;
   logic [NSTAGE-1:0]   hold;
   logic [NSTAGE-1:0]   kill;
   logic [NSTAGE-1:0]   load;
   logic                any_flush;

   logic [CNTW-1:0] retire_cnt_q, stall_cnt_q, flush_cnt_q;

   // Hold propagates from the oldest stage towards the youngest.
   always_comb begin
      logic chain;
      hold  = '0;
      chain = 1'b0;
      for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
         if (COLLAPSE != 0) begin
            hold[i] = valid[i] & (stall_req[i] | chain);
         end else begin
            hold[i] = stall_req[i] | chain;
         end
         chain = hold[i];
      end
   end

   // Kill every stage at or below the highest flush request.
   always_comb begin
      logic seen;
      kill = '0;
      seen = 1'b0;
      for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
         seen    = seen | flush_req[i];
         kill[i] = seen;
      end
   end

   assign any_flush = |flush_req;
   assign in_ready  = ~hold[STG_D] & ~any_flush;

   for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
      logic [W-1:0] src_data;
      if (g == 0) begin : g_head
         assign load[g]  = in_valid & in_ready;
         assign src_data = in_data;
      end else begin : g_body
         // Loads from the previous slot even when that slot is being killed;
         // the kill only clears the killed slots themselves.
         assign load[g]  = valid[g-1] & ~hold[g-1];
         assign src_data = data[(g-1)*W +: W];
      end

      pipe_stage_reg #(
         .W (W)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .kill      (kill[g]),
         .hold      (hold[g]),
         .load      (load[g]),
         .load_data (src_data),
         .valid     (valid[g]),
         .data      (data[g*W +: W])
      );
   end

   assign retire_valid = valid[NSTAGE-1] & ~hold[NSTAGE-1] & ~kill[NSTAGE-1];
   assign retire_data  = data[(NSTAGE-1)*W +: W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_cnt_q <= '0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_q + CNTW'(retire_valid);
         stall_cnt_q  <= stall_cnt_q + CNTW'(hold[STG_D]);
         flush_cnt_q  <= flush_cnt_q + CNTW'(any_flush);
      end
   end

   assign stage_valid = valid;
   assign stage_data  = data;
   assign stage_hold  = hold;
   assign retire_cnt  = retire_cnt_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a lockstep instance (index 0) and a collapse instance
// (index 1) share all inputs. A reference model tracks each instance as
// per-stage instruction slots and decides holds by scanning from a stage
// towards the oldest for a stalled stage.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int N = CORE_NSTAGE;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [N-1:0] stall_req = '0;
   logic [N-1:0] flush_req = '0;

   logic           in_ready     [2];
   logic [N-1:0]   stage_valid  [2];
   logic [N*W-1:0] stage_data   [2];
   logic [N-1:0]   stage_hold   [2];
   logic           retire_valid [2];
   logic [W-1:0]   retire_data  [2];
   pcnt_t          retire_cnt   [2];
   pcnt_t          stall_cnt    [2];
   pcnt_t          flush_cnt    [2];

   int tests = 0;
   int errors = 0;

   pipe_ctrl #(.NSTAGE(N), .W(W), .COLLAPSE(0), .CNTW(32)) u_lock (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready[0]), .stall_req(stall_req), .flush_req(flush_req),
      .stage_valid(stage_valid[0]), .stage_data(stage_data[0]), .stage_hold(stage_hold[0]),
      .retire_valid(retire_valid[0]), .retire_data(retire_data[0]),
      .retire_cnt(retire_cnt[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
   );

   pipe_ctrl #(.NSTAGE(N), .W(W), .COLLAPSE(1), .CNTW(32)) u_coll (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready[1]), .stall_req(stall_req), .flush_req(flush_req),
      .stage_valid(stage_valid[1]), .stage_data(stage_data[1]), .stage_hold(stage_hold[1]),
      .retire_valid(retire_valid[1]), .retire_data(retire_data[1]),
      .retire_cnt(retire_cnt[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
   );

   // ---------------- reference model ----------------
   bit           mv [2][N];
   logic [W-1:0] md [2][N];
   pcnt_t        mret [2];
   pcnt_t        mstl [2];
   pcnt_t        mfl  [2];

   // Stage i is held if some stage at or above i is stalled; in collapse
   // mode an empty stage on the way breaks the chain.
   function automatic bit m_hold(int m, int i);
      for (int j = i; j < N; j++) begin
         if (m == 1 && !mv[m][j]) return 1'b0;
         if (stall_req[j]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int m_fk();
      int fk = -1;
      for (int j = 0; j < N; j++) if (flush_req[j]) fk = j;
      return fk;
   endfunction

   function automatic bit m_ready(int m);
      return !m_hold(m, 0) && (flush_req == '0);
   endfunction

   function automatic bit m_retire(int m);
      return mv[m][N-1] && !m_hold(m, N-1) && (m_fk() < N-1);
   endfunction

   function automatic logic [N-1:0] m_vvec(int m);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = mv[m][i];
      return r;
   endfunction

   function automatic logic [N-1:0] m_hvec(int m);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_hold(m, i);
      return r;
   endfunction

   function automatic logic [N*W-1:0] m_dvec(int m);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = md[m][i];
      return r;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            mv[m][i] = 1'b0;
            md[m][i] = '0;
         end
         mret[m] = '0;
         mstl[m] = '0;
         mfl[m]  = '0;
      end
   endtask

   task automatic model_edge();
      bit           nv [2][N];
      logic [W-1:0] nd [2][N];
      int fk;
      fk = m_fk();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            if (i <= fk) begin
               nv[m][i] = 1'b0;
               nd[m][i] = '0;
            end else if (m_hold(m, i)) begin
               nv[m][i] = mv[m][i];
               nd[m][i] = md[m][i];
            end else if (i == 0) begin
               nv[m][i] = in_valid && m_ready(m);
               nd[m][i] = nv[m][i] ? in_data : '0;
            end else begin
               nv[m][i] = mv[m][i-1] && !m_hold(m, i-1);
               nd[m][i] = nv[m][i] ? md[m][i-1] : '0;
            end
         end
         if (m_retire(m)) mret[m] = mret[m] + 1;
         if (m_hold(m, 0)) mstl[m] = mstl[m] + 1;
         if (flush_req != '0) mfl[m] = mfl[m] + 1;
      end
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            mv[m][i] = nv[m][i];
            md[m][i] = nd[m][i];
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid  = 1'b0;
      in_data   = '0;
      stall_req = '0;
      flush_req = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic fill(int n);
      in_valid = 1'b1;
      for (int k = 1; k <= n; k++) begin
         in_data = W'(k);
         cycle();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      #2;
      for (int m = 0; m < 2; m++) begin
         tests++;
         if (stage_valid[m] !== '0 || stage_data[m] !== '0) begin
            $display("FAIL reset_state m%0d: valid=%b data=%h, want all zero",
                     m, stage_valid[m], stage_data[m]);
            errors++;
         end
         tests++;
         if (retire_cnt[m] !== '0 || stall_cnt[m] !== '0 || flush_cnt[m] !== '0) begin
            $display("FAIL reset_counters m%0d: ret=%0d stall=%0d flush=%0d, want 0",
                     m, retire_cnt[m], stall_cnt[m], flush_cnt[m]);
            errors++;
         end
         tests++;
         if (in_ready[m] !== 1'b1 || retire_valid[m] !== 1'b0) begin
            $display("FAIL reset_outputs m%0d: in_ready=%b retire_valid=%b, want 1/0",
                     m, in_ready[m], retire_valid[m]);
            errors++;
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_stream();
      logic         exp_rv;
      logic [W-1:0] exp_rd;
      do_reset();
      in_valid = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         in_data = W'(n);
         #1;
         exp_rv = (n >= 5);
         exp_rd = (n >= 5) ? W'(n - 4) : '0;
         tests++;
         if ({retire_valid[0], retire_data[0]} !== {exp_rv, exp_rd}) begin
            $display("FAIL stream_retire cycle%0d: got v=%b d=%0d, want v=%b d=%0d",
                     n, retire_valid[0], retire_data[0], exp_rv, exp_rd);
            errors++;
         end
         cycle();
      end
      in_valid = 1'b0;
      tests++;
      if (retire_cnt[0] !== 32'd4) begin
         $display("FAIL stream_retire_cnt: got %0d want 4", retire_cnt[0]);
         errors++;
      end
   endtask

   task automatic test_lockstep_stall();
      int got[$];
      do_reset();
      fill(4);
      in_valid  = 1'b1;
      stall_req = 4'b0010;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) stall_req = '0;
         in_data = (c < 2) ? W'(5) : W'(c + 3);
         #1;
         if (c < 2) begin
            tests++;
            if (in_ready[0] !== 1'b0 || stage_hold[0] !== 4'b0011) begin
               $display("FAIL stall_hold c%0d: in_ready=%b hold=%b, want 0/0011",
                        c, in_ready[0], stage_hold[0]);
               errors++;
            end
         end
         if (retire_valid[0]) got.push_back(int'(retire_data[0]));
         cycle();
         if (c == 0 || c == 1) begin
            tests++;
            if (stage_valid[0] !== ((c == 0) ? 4'b1011 : 4'b0011)) begin
               $display("FAIL stall_bubble c%0d: valid=%b, want %b",
                        c, stage_valid[0], (c == 0) ? 4'b1011 : 4'b0011);
               errors++;
            end
         end
      end
      in_valid = 1'b0;
      tests++;
      if (stall_cnt[0] !== 32'd2) begin
         $display("FAIL stall_cnt: got %0d want 2", stall_cnt[0]);
         errors++;
      end
      tests++;
      if (got.size() != 6) begin
         $display("FAIL stall_retire_count: got %0d retires want 6", got.size());
         errors++;
      end else begin
         for (int k = 0; k < 6; k++) begin
            tests++;
            if (got[k] != k + 1) begin
               $display("FAIL stall_retire_order #%0d: got %0d want %0d", k, got[k], k + 1);
               errors++;
            end
         end
      end
   endtask

   task automatic test_collapse();
      do_reset();
      in_valid = 1'b1; in_data = 1; cycle();
      in_valid = 1'b0; in_data = 0; cycle();
      in_valid = 1'b1; in_data = 2; cycle();
      in_data  = 3; cycle();
      tests++;
      if (stage_valid[1] !== 4'b1011) begin
         $display("FAIL collapse_setup: valid=%b want 1011", stage_valid[1]);
         errors++;
      end
      stall_req = 4'b1000;
      in_data   = 4;
      #1;
      tests++;
      if (stage_hold[1] !== 4'b1000 || in_ready[1] !== 1'b1) begin
         $display("FAIL collapse_hold: hold=%b in_ready=%b want 1000/1",
                  stage_hold[1], in_ready[1]);
         errors++;
      end
      tests++;
      if (stage_hold[0] !== 4'b1111 || in_ready[0] !== 1'b0) begin
         $display("FAIL lockstep_hold: hold=%b in_ready=%b want 1111/0",
                  stage_hold[0], in_ready[0]);
         errors++;
      end
      cycle();
      clear_inputs();
      tests++;
      if (stage_valid[1] !== 4'b1111 || stage_data[1] !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
         $display("FAIL collapse_advance: valid=%b data=%h want 1111 %h",
                  stage_valid[1], stage_data[1], {32'd1, 32'd2, 32'd3, 32'd4});
         errors++;
      end
      tests++;
      if (stage_valid[0] !== 4'b1011 || stage_data[0] !== {32'd1, 32'd0, 32'd2, 32'd3}) begin
         $display("FAIL lockstep_frozen: valid=%b data=%h want 1011 %h",
                  stage_valid[0], stage_data[0], {32'd1, 32'd0, 32'd2, 32'd3});
         errors++;
      end
   endtask

   task automatic test_flush();
      logic [N-1:0] pats [2];
      pats[0] = 4'b0100;
      pats[1] = 4'b0101;
      for (int p = 0; p < 2; p++) begin
         do_reset();
         fill(4);
         flush_req = pats[p];
         in_valid  = 1'b1;
         in_data   = 5;
         #1;
         tests++;
         if (in_ready[0] !== 1'b0 || in_ready[1] !== 1'b0 || retire_valid[0] !== 1'b1) begin
            $display("FAIL flush_ready pat%b: in_ready=%b%b retire_valid=%b want 00/1",
                     pats[p], in_ready[0], in_ready[1], retire_valid[0]);
            errors++;
         end
         cycle();
         clear_inputs();
         for (int m = 0; m < 2; m++) begin
            tests++;
            if (stage_valid[m] !== 4'b1000 || stage_data[m] !== {32'd2, 96'd0}) begin
               $display("FAIL flush_state pat%b m%0d: valid=%b data=%h want 1000 %h",
                        pats[p], m, stage_valid[m], stage_data[m], {32'd2, 96'd0});
               errors++;
            end
         end
         tests++;
         if (flush_cnt[0] !== 32'd1 || retire_cnt[0] !== 32'd1) begin
            $display("FAIL flush_counters pat%b: flush=%0d retire=%0d want 1/1",
                     pats[p], flush_cnt[0], retire_cnt[0]);
            errors++;
         end
      end
   endtask

   task automatic test_flush_stall();
      do_reset();
      fill(4);
      stall_req = 4'b0010;
      flush_req = 4'b0010;
      in_valid  = 1'b1;
      in_data   = 5;
      cycle();
      clear_inputs();
      tests++;
      if (stage_valid[0] !== 4'b1000 || stage_data[0] !== {32'd2, 96'd0}) begin
         $display("FAIL flush_stall_state: valid=%b data=%h want 1000 %h",
                  stage_valid[0], stage_data[0], {32'd2, 96'd0});
         errors++;
      end
      tests++;
      if (stall_cnt[0] !== 32'd1 || flush_cnt[0] !== 32'd1) begin
         $display("FAIL flush_stall_counters: stall=%0d flush=%0d want 1/1",
                  stall_cnt[0], flush_cnt[0]);
         errors++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = $urandom;
         for (int i = 0; i < N; i++) stall_req[i] = ($urandom_range(0, 6) == 0);
         flush_req = ($urandom_range(0, 12) == 0) ? N'($urandom) : '0;
         #1;
         for (int m = 0; m < 2; m++) begin
            tests++;
            if (in_ready[m] !== m_ready(m) || stage_hold[m] !== m_hvec(m) ||
                retire_valid[m] !== m_retire(m) || retire_data[m] !== md[m][N-1]) begin
               $display("FAIL rand_comb c%0d m%0d: rdy=%b hold=%b rv=%b rd=%h want %b %b %b %h",
                        c, m, in_ready[m], stage_hold[m], retire_valid[m], retire_data[m],
                        m_ready(m), m_hvec(m), m_retire(m), md[m][N-1]);
               errors++;
            end
         end
         cycle();
         for (int m = 0; m < 2; m++) begin
            tests++;
            if (stage_valid[m] !== m_vvec(m) || stage_data[m] !== m_dvec(m)) begin
               $display("FAIL rand_state c%0d m%0d: valid=%b data=%h want %b %h",
                        c, m, stage_valid[m], stage_data[m], m_vvec(m), m_dvec(m));
               errors++;
            end
            tests++;
            if (retire_cnt[m] !== mret[m] || stall_cnt[m] !== mstl[m] ||
                flush_cnt[m] !== mfl[m]) begin
               $display("FAIL rand_cnt c%0d m%0d: ret=%0d stall=%0d flush=%0d want %0d %0d %0d",
                        c, m, retire_cnt[m], stall_cnt[m], flush_cnt[m],
                        mret[m], mstl[m], mfl[m]);
               errors++;
            end
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      fill(6);
      stall_req = 4'b0001;
      cycle();
      stall_req = '0;
      #3;
      reset = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         tests++;
         if (stage_valid[m] !== '0 || stage_data[m] !== '0 || retire_cnt[m] !== '0 ||
             stall_cnt[m] !== '0 || flush_cnt[m] !== '0) begin
            $display("FAIL async_reset m%0d: valid=%b data=%h ret=%0d stall=%0d flush=%0d",
                     m, stage_valid[m], stage_data[m], retire_cnt[m], stall_cnt[m],
                     flush_cnt[m]);
            errors++;
         end
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_lockstep_stall();
      test_collapse();
      test_flush();
      test_flush_stall();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
